// File: rtl/aes_round_sched.sv
// aes_round_sched: control/scheduler for an iterative AES round datapath.
// Holds the cipher state between rounds, sequences the round index (0..NR)
// for an external combinational round datapath, and hands out the result
// with a valid/ready handshake. flush aborts the current block.
// Optional feature: define AES_ROUND_SCHED_INV_EN to add in_inv/dp_inv
// (inverse cipher: rounds count down from NR to 0).
module aes_round_sched #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    input  logic         flush,
    output logic         busy,
    output logic [127:0] dp_state,
    output logic [3:0]   dp_round,
    output logic         dp_first,
    output logic         dp_last,
    input  logic [127:0] dp_result
`ifdef AES_ROUND_SCHED_INV_EN
    ,
    input  logic         in_inv,
    output logic         dp_inv
`endif
);

    localparam logic [3:0] LP_NR = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t       r_fsm;
    state_t       w_fsm_nxt;
    logic [127:0] r_state;
    logic [3:0]   r_round;
    logic         w_inv_in;   // direction requested with the offered block
    logic         w_inv_cur;  // direction of the block in flight
    logic [3:0]   w_first_idx;
    logic [3:0]   w_last_idx;
    logic         w_is_first;
    logic         w_is_last;

`ifdef AES_ROUND_SCHED_INV_EN
    logic r_inv;

    assign w_inv_in  = in_inv;
    assign w_inv_cur = r_inv;
    assign dp_inv    = r_inv;

    // Latch the block direction at the input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inv <= 1'b0;
        end else if (!flush && r_fsm == S_IDLE && in_valid) begin
            r_inv <= in_inv;
        end
    end
`else
    assign w_inv_in  = 1'b0;
    assign w_inv_cur = 1'b0;
`endif

    // Round index decode depends only on the registered round and direction.
    always_comb begin
        w_first_idx = w_inv_cur ? LP_NR : 4'd0;
        w_last_idx  = w_inv_cur ? 4'd0 : LP_NR;
        w_is_first  = (r_round == w_first_idx);
        w_is_last   = (r_round == w_last_idx);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // FSM next-state logic; flush overrides every handshake.
    always_comb begin
        w_fsm_nxt = r_fsm;
        if (flush) begin
            w_fsm_nxt = S_IDLE;
        end else begin
            unique case (r_fsm)
                S_IDLE:  if (in_valid)  w_fsm_nxt = S_RUN;
                S_RUN:   if (w_is_last) w_fsm_nxt = S_DONE;
                S_DONE:  if (out_ready) w_fsm_nxt = S_IDLE;
                default: w_fsm_nxt = S_IDLE;
            endcase
        end
    end

    // FSM outputs; in_ready drops during flush so a rejected block never
    // looks accepted to the producer.
    always_comb begin
        in_ready  = (r_fsm == S_IDLE) && !flush;
        out_valid = (r_fsm == S_DONE);
        busy      = (r_fsm != S_IDLE);
        dp_first  = (r_fsm == S_RUN) && w_is_first;
        dp_last   = (r_fsm == S_RUN) && w_is_last;
        dp_round  = r_round;
        dp_state  = r_state;
        out_data  = r_state;
    end

    // State and round registers; round is cleared whenever the block ends so
    // it reads 0 in IDLE, and it saturates at the last index (no wrap).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_round <= '0;
        end else if (flush) begin
            r_state <= '0;
            r_round <= '0;
        end else begin
            unique case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= in_data;
                        r_round <= w_inv_in ? LP_NR : 4'd0;
                    end
                end
                S_RUN: begin
                    r_state <= dp_result;
                    if (!w_is_last) begin
                        r_round <= w_inv_cur ? (r_round - 4'd1) : (r_round + 4'd1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_round <= '0;
                    end
                end
                default: begin
                    r_round <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched with the datapath stubbed as
// dp_result = dp_state + 1, so each block yields in_data + NR + 1.
module tb_aes_round_sched;

`ifdef AES_ROUND_SCHED_INV_EN
    localparam int unsigned LP_NR = 14;
`else
    localparam int unsigned LP_NR = 10;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         flush;
    logic         busy;
    logic [127:0] dp_state;
    logic [3:0]   dp_round;
    logic         dp_first;
    logic         dp_last;
    logic [127:0] dp_result;
    logic         inv_drv;
    logic         w_inv_in;
`ifdef AES_ROUND_SCHED_INV_EN
    logic         dp_inv;
    assign w_inv_in = inv_drv;
`else
    assign w_inv_in = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    assign dp_result = dp_state + 128'd1;

    aes_round_sched #(.NR(LP_NR)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .busy      (busy),
        .dp_state  (dp_state),
        .dp_round  (dp_round),
        .dp_first  (dp_first),
        .dp_last   (dp_last),
        .dp_result (dp_result)
`ifdef AES_ROUND_SCHED_INV_EN
        ,
        .in_inv    (w_inv_in),
        .dp_inv    (dp_inv)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [127:0] exp_q[$];
    int           m_st = 0;          // 0 idle, 1 run, 2 done
    logic [3:0]   m_round = '0;
    logic [127:0] m_data = '0;
    logic         m_inv = 1'b0;
    int           m_lat = 0;
    bit           m_lat_open = 0;
    int           cyc = 0;
    int           hs_cyc = -1;
    bit           b2b_mode = 0;
    int           n_b2b = 0;

    always @(negedge clk) begin
        logic [8:0] e_ctrl;
        logic [3:0] e_first_idx;
        logic [3:0] e_last_idx;
        logic [127:0] popped;
        cyc++;
        if (!b2b_mode) hs_cyc = -1;
        if (!rst_n) begin
            m_st = 0; m_round = '0; m_data = '0; m_inv = 1'b0; m_lat_open = 0;
            exp_q.delete();
        end else begin
            m_lat++;
            e_first_idx = m_inv ? 4'(LP_NR) : 4'd0;
            e_last_idx  = m_inv ? 4'd0 : 4'(LP_NR);
            e_ctrl = {(m_st == 0) && !flush, m_st != 0, m_st == 2,
                      (m_st == 1) && (m_round == e_first_idx),
                      (m_st == 1) && (m_round == e_last_idx),
                      (m_st == 0) ? 4'd0 : m_round};
            check("ctrl", {in_ready, busy, out_valid, dp_first, dp_last, dp_round}, e_ctrl);
            if (m_st != 0) check("dp_state", dp_state, m_data);
`ifdef AES_ROUND_SCHED_INV_EN
            if (m_st != 0) check("dp_inv", dp_inv, m_inv);
`endif
            if (m_st == 2 && exp_q.size() > 0) check("out_hold", out_data, exp_q[0]);
            if (out_valid && m_lat_open) begin
                check("latency", m_lat - 1, LP_NR + 1);
                m_lat_open = 0;
            end
            if (flush) begin
                if (m_st != 0 && exp_q.size() > 0) void'(exp_q.pop_back());
                m_st = 0; m_round = '0; m_data = '0; m_lat_open = 0;
            end else begin
                case (m_st)
                    0: if (in_valid) begin
                        if (b2b_mode && hs_cyc >= 0) begin
                            check("b2b_gap", cyc - hs_cyc, 1);
                            n_b2b++;
                        end
                        exp_q.push_back(in_data + 128'(LP_NR + 1));
                        m_data = in_data;
                        m_inv = w_inv_in;
                        m_round = w_inv_in ? 4'(LP_NR) : 4'd0;
                        m_st = 1; m_lat = 0; m_lat_open = 1;
                    end
                    1: begin
                        m_data = m_data + 128'd1;
                        if (m_round == e_last_idx) m_st = 2;
                        else m_round = m_inv ? m_round - 4'd1 : m_round + 4'd1;
                    end
                    default: if (out_ready) begin
                        popped = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                        check("out_data", out_data, popped);
                        hs_cyc = cyc;
                        m_st = 0; m_round = '0;
                    end
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [127:0] d, input logic inv);
        bit ok = 0;
        in_data = d; inv_drv = inv; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) check("valid_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; inv_drv = 1'b0;
        #3;
        check("rst_ctrl", {busy, out_valid, dp_first, dp_last, dp_round}, '0);
        check("rst_state", dp_state, '0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // basic block: in_data = 0 -> 0x0B after NR+1 rounds
        out_ready = 1'b1;
        send('0, 1'b0);
        wait_idle();

        // consumer stall for 5 cycles with in_valid offered meanwhile
        out_ready = 1'b0;
        send(rnd128(), 1'b0);
        wait_valid();
        in_valid = 1'b1; in_data = rnd128();
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // flush at round 4, then a normal block
        send(rnd128(), 1'b0);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_idle", {busy, out_valid}, 2'b00);
        @(posedge clk); #1;
        send(rnd128(), 1'b0);
        wait_idle();

        // flush in IDLE rejects an offered block
        in_valid = 1'b1; flush = 1'b1; in_data = rnd128();
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_reject", busy, 1'b0);
        @(posedge clk); #1;

        // asynchronous reset mid-RUN
        send(rnd128(), 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_ctrl", {busy, out_valid, dp_first, dp_last, dp_round}, '0);
        check("arst_state", dp_state, '0);
        @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back blocks, in_valid held high
        b2b_mode = 1;
        in_valid = 1'b1;
        for (int i = 0; i < 3 * (LP_NR + 3); i++) begin
            in_data = rnd128();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle();
        b2b_mode = 0;
        check("b2b_seen", n_b2b > 0, 1'b1);

`ifdef AES_ROUND_SCHED_INV_EN
        send(rnd128(), 1'b1);
        wait_idle();
`endif

        // random blocks with random consumer delay
        for (int k = 0; k < 6; k++) begin
            out_ready = 1'b0;
            send(rnd128(), 1'($urandom_range(0, 1)));
            wait_valid();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 out_ready = 1'b1;
            wait_idle();
        end

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_round_sched.md
AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 Parameter NR, default 10, number of cipher rounds; legal values 10, 12, 14.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  input block offered.
REQ-005 in_ready  output  1  scheduler accepts a block.
REQ-006 in_data  input  128  input block, byte 0 in bits [127:120].
REQ-007 out_valid  output  1  result block available.
REQ-008 out_ready  input  1  consumer takes the result.
REQ-009 out_data  output  128  result block.
REQ-010 flush  input  1  synchronous abort of the current block.
REQ-011 busy  output  1  high in RUN or DONE.
REQ-012 dp_state  output  128  state fed to the external round datapath.
REQ-013 dp_round  output  4  round index for the datapath and key selection.
REQ-014 dp_first  output  1  high when dp_round is the initial AddRoundKey-only round.
REQ-015 dp_last  output  1  high when dp_round is the final round, with MixColumns skipped.
REQ-016 dp_result  input  128  combinational datapath result for dp_state and dp_round.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-018 IDLE: in_ready=1; on in_valid&&in_ready, state_q<=in_data, round_q<=first index, and the FSM moves to RUN.
REQ-019 RUN: dp_state=state_q and dp_round=round_q; each cycle state_q<=dp_result and round_q steps one index.
REQ-020 RUN SHALL last exactly NR+1 cycles (rounds 0..NR); after the cycle with dp_last=1 the FSM moves to DONE.
REQ-021 DONE: out_valid=1 and out_data=state_q, both held stable until out_valid&&out_ready, then the FSM moves to IDLE.
REQ-022 in_ready SHALL be 0 in RUN and DONE; a new block is accepted no earlier than the first cycle after the output handshake.
REQ-023 Latency from the input handshake edge to out_valid high SHALL be NR+1 cycles.
REQ-024 dp_first, dp_last and dp_round SHALL be decoded from round_q only; dp_first and dp_last are 0 outside RUN.
REQ-025 dp_state SHALL equal state_q in every state; dp_round SHALL be 0 in IDLE.
REQ-026 round_q SHALL never leave the range 0..NR; there is no wrap-around.
REQ-027 flush=1 in any state SHALL force IDLE on the next edge, discard state_q and drop out_valid. flush has priority over every other event, including a same-cycle input or output handshake.
REQ-028 flush in IDLE together with in_valid SHALL reject the block (no accept).
REQ-029 busy SHALL be 1 exactly when the state is RUN or DONE.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE, state_q=0, round_q=0, out_valid=0, busy=0, and in_ready=1 once rst_n is released.
REQ-031 Reset mid-RUN or mid-DONE SHALL abandon the block; no partial result is ever presented.

Configuration
REQ-032 Macro AES_ROUND_SCHED_INV_EN, when defined, SHALL add:
- input in_inv (1 bit), sampled at the input handshake;
- output dp_inv (1 bit), held for the whole block.
REQ-033 With the macro defined and in_inv=1, round_q SHALL start at NR and count down to 0.
- dp_first is high at round NR.
- dp_last is high at round 0.
- Latency is unchanged.
REQ-034 Without the macro, in_inv and dp_inv SHALL not exist, and rounds always count up from 0 to NR.

Verification
REQ-035 NR=10, with the datapath stubbed as dp_result=dp_state+1: accept in_data=0 -> out_valid 11 cycles later, out_data=0x0B; dp_first only at round 0, dp_last only at round 10.
REQ-036 out_ready held low for 5 cycles in DONE -> out_valid and out_data stable throughout; in_ready=0; in_valid ignored.
REQ-037 flush asserted at round 4 -> IDLE on the next edge, out_valid never asserted, and the next block completes normally.
REQ-038 rst_n pulsed low mid-RUN -> all outputs at reset values immediately, with no clock required.
REQ-039 With AES_ROUND_SCHED_INV_EN, NR=14, in_inv=1 -> dp_round sequence 14..0, dp_last at round 0, out_valid 15 cycles after accept.
REQ-040 Back-to-back blocks, with in_valid held high and out_ready=1 -> second accept on the cycle after the output handshake, with no overlap of blocks.
